// File: rtl/mlp_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_stream_loader_pkg
//  Description : Shared constants and FSM state type for the MLP stream loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mlp_stream_loader_pkg;

    localparam int IFMAP_WORDS    = 16;
    localparam int WEIGHT_WORDS   = 1024;
    localparam int BIAS_WORDS     = 64;
    localparam int STREAM_WORDS   = IFMAP_WORDS + WEIGHT_WORDS + BIAS_WORDS;  // 1104
    localparam int OFMAP_PER_STEP = 64;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 11;
    localparam int CAP_W  = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        STREAM  = 3'd2,
        COLLECT = 3'd3,
        FIN     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mlp_stream_loader_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_addr_gen
//  Description : Combinational read-address generator for the layer stream.
//                Word k of a step is ifmap (k<16), weight (j=k-16) or
//                bias (b=k-1040); all arithmetic wraps at 16 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_addr_gen
    import mlp_stream_loader_pkg::*;
(
    input  logic                mode_i,
    input  logic                step_i,
    input  logic [CNT_W-1:0]    cnt_i,
    input  logic [ADDR_W-1:0]   ifmap_base_i,
    input  logic [ADDR_W-1:0]   weight_base_i,
    input  logic [ADDR_W-1:0]   bias_base_i,
    output logic [ADDR_W-1:0]   rd_addr_o
);

    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] step16;

    // Select the stream region and apply the per-mode address rule.
    always_comb begin
        k      = {{(ADDR_W-CNT_W){1'b0}}, cnt_i};
        j      = k - ADDR_W'(IFMAP_WORDS);
        b      = k - ADDR_W'(IFMAP_WORDS + WEIGHT_WORDS);
        step16 = {{(ADDR_W-1){1'b0}}, step_i};
        if (k < ADDR_W'(IFMAP_WORDS)) begin
            // MLP3 consumes the second half of the 32-entry ifmap in step 1
            if (mode_i) rd_addr_o = ifmap_base_i + (step16 << 4) + k;
            else        rd_addr_o = ifmap_base_i + k;
        end else if (k < ADDR_W'(IFMAP_WORDS + WEIGHT_WORDS)) begin
            // MLP3 weight rows are 32 wide; each step takes one 16-wide half
            if (mode_i) rd_addr_o = weight_base_i + ((j >> 4) << 5) + (step16 << 4)
                                    + (j & 16'h000F);
            else        rd_addr_o = weight_base_i + (step16 << 10) + j;
        end else begin
            // MLP3 step 1 re-reads the partial sums written over the bias area
            if (mode_i) rd_addr_o = bias_base_i + b;
            else        rd_addr_o = bias_base_i + (step16 << 6) + b;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mlp_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_stream_loader
//  Description : Streams ifmap/weight/bias words from memory to an MLP
//                accelerator in two steps and writes its ofmap words back.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_stream_loader
    import mlp_stream_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] ifmap_base,
    input  logic [15:0] weight_base,
    input  logic [15:0] bias_base,
    input  logic [15:0] ofmap_base,
    output logic        mem_rd_en,
    output logic [15:0] mem_rd_addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [15:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        acc_ready,
    output logic [31:0] acc_data,
    input  logic        acc_valid,
    input  logic [31:0] acc_ofmap,
    output logic        busy,
    output logic        done
);

    state_e              state_q;
    logic                step_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CAP_W-1:0]    cap_q;
    logic [CAP_W-1:0]    cap_d;
    logic                mode_q;
    logic [ADDR_W-1:0]   ifmap_base_q;
    logic [ADDR_W-1:0]   weight_base_q;
    logic [ADDR_W-1:0]   bias_base_q;
    logic [ADDR_W-1:0]   ofmap_base_q;
    logic                data_vld_q;
    logic                busy_q;
    logic                done_q;

    logic                arm_fire;
    logic                rd_fire;
    logic                cap_fire;
    logic [ADDR_W-1:0]   gen_rd_addr;
    logic [ADDR_W-1:0]   wr_addr_calc;
    logic [ADDR_W-1:0]   cap_n;
    logic [ADDR_W-1:0]   step16;

    mlp_addr_gen u_addr_gen (
        .mode_i        (mode_q),
        .step_i        (step_q),
        .cnt_i         (cnt_q),
        .ifmap_base_i  (ifmap_base_q),
        .weight_base_i (weight_base_q),
        .bias_base_i   (bias_base_q),
        .rd_addr_o     (gen_rd_addr)
    );

    // Strobes: ARM only fires once the accelerator has dropped its valid.
    always_comb begin
        arm_fire = (state_q == ARM) && !acc_valid;
        rd_fire  = arm_fire || (state_q == STREAM);
        cap_fire = acc_valid
                   && ((state_q == ARM) || (state_q == STREAM) || (state_q == COLLECT))
                   && (cap_q < CAP_W'(OFMAP_PER_STEP));
        cap_d    = cap_fire ? cap_q + CAP_W'(1) : cap_q;
    end

    // Ofmap destination: MLP3 step 0 overwrites the bias area with partial sums.
    always_comb begin
        cap_n  = {{(ADDR_W-CAP_W){1'b0}}, cap_q};
        step16 = {{(ADDR_W-1){1'b0}}, step_q};
        if (!mode_q)      wr_addr_calc = ofmap_base_q + (step16 << 6) + cap_n;
        else if (!step_q) wr_addr_calc = bias_base_q + cap_n;
        else              wr_addr_calc = ofmap_base_q + cap_n;
    end

    // Memory and accelerator ports; idle values are forced to zero.
    always_comb begin
        mem_rd_en   = rd_fire;
        mem_rd_addr = rd_fire ? gen_rd_addr : '0;
        mem_wr_en   = cap_fire;
        mem_wr_addr = cap_fire ? wr_addr_calc : '0;
        mem_wr_data = cap_fire ? acc_ofmap : '0;
        acc_ready   = arm_fire;
        acc_data    = data_vld_q ? mem_rdata : '0;
        busy        = busy_q;
        done        = done_q;
    end

    // Layer sequencer: two steps of 1104 streamed words and 64 captures each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            step_q        <= 1'b0;
            cnt_q         <= '0;
            cap_q         <= '0;
            mode_q        <= 1'b0;
            ifmap_base_q  <= '0;
            weight_base_q <= '0;
            bias_base_q   <= '0;
            ofmap_base_q  <= '0;
            data_vld_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            data_vld_q <= rd_fire;
            cap_q      <= cap_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= ARM;
                        step_q        <= 1'b0;
                        cnt_q         <= '0;
                        cap_q         <= '0;
                        mode_q        <= mode;
                        ifmap_base_q  <= ifmap_base;
                        weight_base_q <= weight_base;
                        bias_base_q   <= bias_base;
                        ofmap_base_q  <= ofmap_base;
                        busy_q        <= 1'b1;
                    end
                end
                ARM: begin
                    if (!acc_valid) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (cnt_q == CNT_W'(STREAM_WORDS - 1)) state_q <= COLLECT;
                    else                                   cnt_q   <= cnt_q + CNT_W'(1);
                end
                COLLECT: begin
                    if (cap_q == CAP_W'(OFMAP_PER_STEP)) begin
                        if (!step_q) begin
                            step_q  <= 1'b1;
                            cnt_q   <= '0;
                            cap_q   <= '0;
                            state_q <= ARM;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mlp_stream_loader
//  Description : Self-checking bench for mlp_stream_loader with a memory
//                model, a randomised accelerator and a per-layer timeline plan.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_stream_loader;

    localparam int MAXC = 4096;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] ifmap_base, weight_base, bias_base, ofmap_base;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        acc_ready;
    logic [31:0] acc_data;
    logic        acc_valid;
    logic [31:0] acc_ofmap;
    logic        busy;
    logic        done;

    mlp_stream_loader dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .ifmap_base(ifmap_base), .weight_base(weight_base),
        .bias_base(bias_base), .ofmap_base(ofmap_base),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .acc_ready(acc_ready), .acc_data(acc_data),
        .acc_valid(acc_valid), .acc_ofmap(acc_ofmap),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory (1-cycle read latency) and the bench's expected image.
    logic [31:0] env_mem [0:65535];
    logic [31:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_wr_en) env_mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rdata <= env_mem[mem_rd_addr];
    end

    // Per-cycle plan of one layer, indexed from the start cycle.
    bit          plan_start   [0:MAXC-1];
    bit          plan_valid   [0:MAXC-1];
    logic [31:0] plan_ofm     [0:MAXC-1];
    bit          plan_wr      [0:MAXC-1];
    logic [15:0] plan_wr_addr [0:MAXC-1];
    bit          plan_rd      [0:MAXC-1];
    logic [15:0] plan_rd_addr [0:MAXC-1];
    bit          plan_ready   [0:MAXC-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd_addr(input bit md, input int st, input int k,
                                                input logic [15:0] ib, input logic [15:0] wb,
                                                input logic [15:0] bb);
        int a, j, b;
        j = k - 16;
        b = k - 1040;
        if (k < 16)        a = md ? int'(ib) + 16*st + k : int'(ib) + k;
        else if (k < 1040) a = md ? int'(wb) + 32*(j/16) + 16*st + (j%16)
                                  : int'(wb) + 1024*st + j;
        else               a = md ? int'(bb) + b : int'(bb) + 64*st + b;
        return a[15:0];
    endfunction

    function automatic logic [15:0] ref_wr_addr(input bit md, input int st, input int n,
                                                input logic [15:0] bb, input logic [15:0] ob);
        int a;
        if (!md)         a = int'(ob) + 64*st + n;
        else if (st == 0) a = int'(bb) + n;
        else             a = int'(ob) + n;
        return a[15:0];
    endfunction

    task automatic plan_capture(input int c, input bit md, input int st, input int n,
                                input bit take, input logic [15:0] bb, input logic [15:0] ob);
        plan_valid[c] = 1'b1;
        plan_ofm[c]   = $urandom;
        if (take) begin
            plan_wr[c]      = 1'b1;
            plan_wr_addr[c] = ref_wr_addr(md, st, n, bb, ob);
        end
    endtask

    // Build the timeline: ARM of step s at a_s, word k read at a_s+k,
    // next ARM one cycle after both the stream end and the 64th capture.
    task automatic build_plan(input bit md, input logic [15:0] ib, input logic [15:0] wb,
                              input logic [15:0] bb, input logic [15:0] ob,
                              input int stall, input int extra,
                              output int fin, output int last_evt);
        int a0, a1, c, n, last0, last1;
        for (int i = 0; i < MAXC; i++) begin
            plan_start[i] = 0; plan_valid[i] = 0; plan_ofm[i] = '0; plan_wr[i] = 0;
            plan_wr_addr[i] = '0; plan_rd[i] = 0; plan_rd_addr[i] = '0; plan_ready[i] = 0;
        end
        plan_start[0] = 1'b1;
        n = 0;
        last0 = 0;
        // valid held across the start cycle: ignored in IDLE, captured while ARM stalls
        for (int i = 0; i < stall; i++) begin
            plan_capture(i, md, 0, n, (i >= 1), bb, ob);
            if (i >= 1) begin n++; last0 = i; end
        end
        a0 = (stall > 0) ? stall : 1;
        c = a0 + int'($urandom_range(1, 1200));
        while (n < 64) begin
            plan_capture(c, md, 0, n, 1'b1, bb, ob);
            last0 = c; n++;
            c += 1 + int'($urandom_range(0, 3));
        end
        a1 = ((a0 + 1104 > last0 + 1) ? a0 + 1104 : last0 + 1) + 1;
        c = a1 + int'($urandom_range(1, 1200));
        n = 0;
        last1 = 0;
        last_evt = 0;
        while (n < 64 + extra) begin
            plan_capture(c, md, 1, n, (n < 64), bb, ob);
            if (n == 63) last1 = c;
            last_evt = c; n++;
            c += 1 + int'($urandom_range(0, 3));
        end
        plan_ready[a0] = 1'b1;
        plan_ready[a1] = 1'b1;
        for (int k = 0; k < 1104; k++) begin
            plan_rd[a0+k] = 1'b1; plan_rd_addr[a0+k] = ref_rd_addr(md, 0, k, ib, wb, bb);
            plan_rd[a1+k] = 1'b1; plan_rd_addr[a1+k] = ref_rd_addr(md, 1, k, ib, wb, bb);
        end
        fin = ((a1 + 1104 > last1 + 1) ? a1 + 1104 : last1 + 1) + 1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},    busy, 0);
        check_val({tag, "_done"},    done, 0);
        check_val({tag, "_ready"},   acc_ready, 0);
        check_val({tag, "_accdata"}, acc_data, 0);
        check_val({tag, "_rd_en"},   mem_rd_en, 0);
        check_val({tag, "_rd_addr"}, mem_rd_addr, 0);
        check_val({tag, "_wr_en"},   mem_wr_en, 0);
        check_val({tag, "_wr_addr"}, mem_wr_addr, 0);
        check_val({tag, "_wr_data"}, mem_wr_data, 0);
    endtask

    task automatic run_layer(input bit md, input logic [15:0] ib, input logic [15:0] wb,
                             input logic [15:0] bb, input logic [15:0] ob,
                             input int stall, input int extra, input bit dup, input int abort_at);
        int fin, last_evt, ncyc;
        bit pend;
        logic [31:0] pend_val;
        build_plan(md, ib, wb, bb, ob, stall, extra, fin, last_evt);
        if (dup) plan_start[$urandom_range(2, fin)] = 1'b1;
        ncyc = ((fin > last_evt) ? fin : last_evt) + 6;
        pend = 0;
        pend_val = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start     = plan_start[c];
            acc_valid = plan_valid[c];
            acc_ofmap = plan_valid[c] ? plan_ofm[c] : $urandom;
            if (c == 0) begin
                mode = md; ifmap_base = ib; weight_base = wb; bias_base = bb; ofmap_base = ob;
            end else begin
                mode = 1'($urandom); ifmap_base = 16'($urandom); weight_base = 16'($urandom);
                bias_base = 16'($urandom); ofmap_base = 16'($urandom);
            end
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1 check_all_zero("abort");
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
            check_val("acc_ready", acc_ready, plan_ready[c]);
            check_val("rd_en", mem_rd_en, plan_rd[c]);
            if (plan_rd[c]) check_val("rd_addr", mem_rd_addr, plan_rd_addr[c]);
            check_val("acc_data", acc_data, pend ? pend_val : 32'd0);
            pend = plan_rd[c];
            if (pend) pend_val = ref_mem[plan_rd_addr[c]];
            check_val("wr_en", mem_wr_en, plan_wr[c]);
            if (plan_wr[c]) begin
                check_val("wr_addr", mem_wr_addr, plan_wr_addr[c]);
                check_val("wr_data", mem_wr_data, plan_ofm[c]);
                ref_mem[plan_wr_addr[c]] = plan_ofm[c];
            end
            check_val("busy", busy, (c >= 1) && (c <= fin));
            check_val("done", done, c == fin);
        end
        start = 1'b0;
        acc_valid = 1'b0;
    endtask

    // Idle after reset: stray valid pulses must cause no memory traffic.
    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            acc_valid = 1'($urandom);
            acc_ofmap = $urandom;
            @(negedge clk);
            check_val("idle_rd_en", mem_rd_en, 0);
            check_val("idle_wr_en", mem_wr_en, 0);
            check_val("idle_busy", busy, 0);
        end
        acc_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; start = 1'b0; mode = 1'b0; acc_valid = 1'b0; acc_ofmap = '0;
        ifmap_base = '0; weight_base = '0; bias_base = '0; ofmap_base = '0;
        mem_rdata = '0;
        for (int i = 0; i < 65536; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        run_layer(1'b0, 16'h0100, 16'h1000, 16'h2000, 16'h3000, 0, 0, 1'b1, -1);
        run_layer(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 3, 1'b0, -1);
        run_layer(1'b0, 16'hFFF8, 16'($urandom), 16'($urandom), 16'($urandom), 6, 0, 1'b0, -1);
        run_layer(1'b1, 16'hFFF8, 16'($urandom), 16'($urandom), 16'($urandom), 4, 5, 1'b1, -1);
        run_layer(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, 1'b0, 501);
        idle_check(16);
        run_layer(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 2, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
